// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG         = 32;
  localparam int unsigned REG_AW       = 5;

  typedef enum logic {PIPE_PRI, FORCE} arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for long-latency destinations plus outstanding-operation count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned MaxOut = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  output logic              issue_ready_o,
  input  logic              wb1_hs_i,
  input  logic [REG_AW-1:0] wb1_rd_i,
  output logic [NREG-1:0]   busy_o
);

  localparam int unsigned CntW = $clog2(MaxOut + 1);

  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            issue_acc;

  always_comb begin
    issue_ready_o = (out_cnt_q < CntW'(MaxOut)) &&
                    ((issue_rd_i == '0) || !busy_q[issue_rd_i]);
    issue_acc     = issue_valid_i && issue_ready_o;
  end

  always_comb begin
    busy_d    = busy_q;
    out_cnt_d = out_cnt_q;
    // Clear before set so a same-register issue keeps the bit high.
    if (wb1_hs_i) busy_d[wb1_rd_i] = 1'b0;
    if (issue_acc) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (issue_acc && !wb1_hs_i) begin
      out_cnt_d = out_cnt_q + CntW'(1);
    end else if (!issue_acc && wb1_hs_i && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// long-latency unit, forcing a one-cycle pipeline stall when the long unit starves.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_rd,
  input  logic [XLEN-1:0]   wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic [XLEN-1:0]   wb1_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              pipe_stall,
  output logic [NREG-1:0]   busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  arb_state_t       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             sb_issue_ready;
  logic             wb1_hs;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= PIPE_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      PIPE_PRI: begin
        if (wb1_valid && !wb1_ready) begin
          if (wait_q == WaitW'(MAX_WAIT - 1)) begin
            state_d = FORCE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
      FORCE: begin
        state_d = PIPE_PRI;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs are gated by nrst so an in-flight grant drops the moment reset asserts.
  always_comb begin
    wb1_ready  = 1'b0;
    pipe_stall = 1'b0;
    rf_we      = 1'b0;
    rf_a3      = '0;
    rf_wd      = '0;
    if (nrst) begin
      unique case (state_q)
        PIPE_PRI: begin
          if (wb0_valid && (wb0_rd != '0)) begin
            rf_we = 1'b1;
            rf_a3 = wb0_rd;
            rf_wd = wb0_data;
          end else if (wb1_valid) begin
            wb1_ready = 1'b1;
            if (wb1_rd != '0) begin
              rf_we = 1'b1;
              rf_a3 = wb1_rd;
              rf_wd = wb1_data;
            end
          end
        end
        FORCE: begin
          pipe_stall = 1'b1;
          wb1_ready  = 1'b1;
          if (wb1_valid && (wb1_rd != '0)) begin
            rf_we = 1'b1;
            rf_a3 = wb1_rd;
            rf_wd = wb1_data;
          end
        end
      endcase
    end
  end

  assign wb1_hs      = wb1_valid && wb1_ready;
  assign issue_ready = nrst && sb_issue_ready;

  rf_scoreboard #(
    .MaxOut(MAX_OUT)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (nrst),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .issue_ready_o(sb_issue_ready),
    .wb1_hs_i     (wb1_hs),
    .wb1_rd_i     (wb1_rd),
    .busy_o       (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned MAX_OUT  = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic            wb0_valid, wb1_valid, issue_valid;
  logic [4:0]      wb0_rd, wb1_rd, issue_rd;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic            wb1_ready, issue_ready, pipe_stall, rf_we;
  logic [31:0]     busy;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN    (XLEN),
    .MAX_WAIT(MAX_WAIT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .wb0_valid  (wb0_valid),
    .wb0_rd     (wb0_rd),
    .wb0_data   (wb0_data),
    .wb1_valid  (wb1_valid),
    .wb1_ready  (wb1_ready),
    .wb1_rd     (wb1_rd),
    .wb1_data   (wb1_data),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_rd   (issue_rd),
    .pipe_stall (pipe_stall),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: "forced" means this cycle is the starvation grant; refusals counts
  // consecutive cycles WB1 was offered but refused.
  bit        m_force;
  int        m_refused;
  bit [31:0] m_busy;
  int        m_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_force   = 1'b0;
    m_refused = 0;
    m_busy    = '0;
    m_out     = 0;
  endtask

  task automatic set_idle();
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  // Drive one cycle, check every output against the model, then advance the model.
  task automatic cyc(input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
                     input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
                     input bit iv, input logic [4:0] ird);
    bit          e_w1r, e_we, e_ir, hs, acc;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    @(negedge clk);
    wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    issue_valid = iv; issue_rd = ird;
    #1;
    e_we = 1'b0; e_a3 = '0; e_wd = '0;
    if (!m_force && v0 && rd0 != 0) begin
      e_w1r = 1'b0; e_we = 1'b1; e_a3 = rd0; e_wd = d0;
    end else begin
      e_w1r = m_force ? 1'b1 : v1;
      if (v1 && rd1 != 0) begin
        e_we = 1'b1; e_a3 = rd1; e_wd = d1;
      end
    end
    e_ir = (m_out < int'(MAX_OUT)) && (ird == 0 || !m_busy[ird]);
    check("pipe_stall", 64'(pipe_stall), 64'(m_force));
    check("wb1_ready", 64'(wb1_ready), 64'(e_w1r));
    check("rf_we", 64'(rf_we), 64'(e_we));
    if (e_we) begin
      check("rf_a3", 64'(rf_a3), 64'(e_a3));
      check("rf_wd", 64'(rf_wd), 64'(e_wd));
    end
    check("issue_ready", 64'(issue_ready), 64'(e_ir));
    check("busy", 64'(busy), 64'(m_busy));
    hs  = v1 && e_w1r;
    acc = iv && e_ir;
    if (m_force) begin
      m_force = 1'b0; m_refused = 0;
    end else if (v1 && !e_w1r) begin
      m_refused++;
      if (m_refused == int'(MAX_WAIT)) begin
        m_force = 1'b1; m_refused = 0;
      end
    end else begin
      m_refused = 0;
    end
    if (hs) m_busy[rd1] = 1'b0;
    if (acc && ird != 0) m_busy[ird] = 1'b1;
    m_out = m_out + int'(acc) - int'(hs);
    if (m_out < 0) m_out = 0;
  endtask

  initial begin
    set_idle();
    nrst = 1'b0;
    model_reset();
    // Requests present during reset must not leak through.
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h1234;
    wb1_valid = 1; wb1_rd = 6; issue_valid = 1; issue_rd = 2;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(pipe_stall), 64'd0);
    check("rst_wb1_ready", 64'(wb1_ready), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd0);
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_a3", 64'(rf_a3), 64'd0);
    check("rst_wd", 64'(rf_wd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    set_idle();
    nrst = 1'b1;

    // WB0 write goes straight to the port.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("tp1_we", 64'(rf_we), 64'd1);
    check("tp1_a3", 64'(rf_a3), 64'd5);
    check("tp1_wd", 64'(rf_wd), 64'hDEADBEEF);
    check("tp1_wb1_ready", 64'(wb1_ready), 64'd0);

    // WB0 to x0 yields the port to WB1.
    cyc(1, 0, 32'h55, 1, 7, 32'h11, 0, 0);
    check("tp2_a3", 64'(rf_a3), 64'd7);
    check("tp2_wd", 64'(rf_wd), 64'h11);
    check("tp2_wb1_ready", 64'(wb1_ready), 64'd1);

    // Starvation: four refusals, then a forced grant, then WB0 priority again.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 3, 32'hA0 + 32'(i), 1, 9, 32'h99, 0, 0);
      check($sformatf("tp3_stall_c%0d", i), 64'(pipe_stall), 64'(i == 4));
      check($sformatf("tp3_wb1_ready_c%0d", i), 64'(wb1_ready), 64'(i == 4));
      check($sformatf("tp3_a3_c%0d", i), 64'(rf_a3), (i == 4) ? 64'd9 : 64'd3);
    end

    // Scoreboard set / block / clear.
    cyc(0, 0, 0, 0, 0, 0, 1, 10);
    cyc(0, 0, 0, 0, 0, 0, 1, 10);
    check("tp4_busy10_set", 64'(busy[10]), 64'd1);
    check("tp4_reissue_blocked", 64'(issue_ready), 64'd0);
    cyc(0, 0, 0, 1, 10, 32'h1234, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 10);
    check("tp4_busy10_clr", 64'(busy[10]), 64'd0);
    check("tp4_ready10", 64'(issue_ready), 64'd1);

    // Outstanding limit.
    for (int r = 1; r <= 4; r++) cyc(0, 0, 0, 0, 0, 0, 1, 5'(r));
    cyc(0, 0, 0, 0, 0, 0, 1, 5);
    check("tp5_full", 64'(issue_ready), 64'd0);
    cyc(0, 0, 0, 1, 1, 32'h77, 1, 5);
    check("tp5_same_cycle", 64'(issue_ready), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5);
    check("tp5_accept", 64'(issue_ready), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp5_busy5", 64'(busy[5]), 64'd1);
    check("tp5_busy1", 64'(busy[1]), 64'd0);
    for (int r = 2; r <= 5; r++) cyc(0, 0, 0, 1, 5'(r), 32'(r), 0, 0);

    // Reset asserted in the middle of a forced grant.
    cyc(0, 0, 0, 0, 0, 0, 1, 10);
    for (int i = 0; i < 5; i++) cyc(1, 3, 32'hB0, 1, 9, 32'hC0, 0, 0);
    check("tp6_in_force", 64'(pipe_stall), 64'd1);
    check("tp6_busy_pre", 64'(busy), 64'h400);
    nrst = 1'b0;
    #1;
    check("tp6_stall", 64'(pipe_stall), 64'd0);
    check("tp6_wb1_ready", 64'(wb1_ready), 64'd0);
    check("tp6_we", 64'(rf_we), 64'd0);
    check("tp6_a3", 64'(rf_a3), 64'd0);
    check("tp6_wd", 64'(rf_wd), 64'd0);
    check("tp6_busy", 64'(busy), 64'd0);
    set_idle();
    #1;
    nrst = 1'b1;
    model_reset();
    cyc(1, 3, 32'hE0, 1, 9, 32'hE1, 0, 0);
    check("tp6_post_stall", 64'(pipe_stall), 64'd0);
    check("tp6_post_wb1_ready", 64'(wb1_ready), 64'd0);

    // Random traffic; small register range to provoke busy collisions.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) between two requesters: the in-order pipeline writeback (WB0) and a long-latency unit such as load/mul-div (WB1). It also keeps a per-register busy scoreboard for WB1 destinations, which the hazard logic uses. The block sits between the writeback stage, the long-latency unit and the register file. A starvation counter guarantees WB1 progress by stalling the pipeline for one cycle.

Parameters:
XLEN, 32, data width
MAX_WAIT, 4, consecutive cycles WB1 may be refused before a forced grant (>=1)
MAX_OUT, 4, max outstanding issued WB1 operations (>=1)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
wb0_valid  in  1  pipeline writeback request (no backpressure except pipe_stall)
wb0_rd  in  5  pipeline destination register
wb0_data  in  XLEN  pipeline write data
wb1_valid  in  1  long-unit result valid
wb1_ready  out  1  long-unit result accepted this cycle
wb1_rd  in  5  long-unit destination register
wb1_data  in  XLEN  long-unit write data
issue_valid  in  1  long-unit operation being issued
issue_ready  out  1  issue may be accepted
issue_rd  in  5  destination register of the issued operation
pipe_stall  out  1  pipeline must hold WB0 inputs this cycle
busy  out  32  scoreboard; bit r = r has an outstanding WB1 write; bit 0 always 0
rf_we  out  1  to register file WE3
rf_a3  out  5  to register file A3
rf_wd  out  XLEN  to register file WD3

Behaviour:
- Reset (nrst=0, asynchronous): state=PIPE_PRI, wait_cnt=0, out_cnt=0, busy=0. Outputs go to pipe_stall=0, wb1_ready=0, issue_ready=0. rf_we=0, rf_a3=0, rf_wd=0.
- Write port is combinational from the current state and inputs. The register file captures the write on the clock edge that ends the grant cycle, so latency is 0.
- A request with rd=0 consumes no port slot and keeps rf_we=0. It counts as accepted: WB0 completes, and WB1 handshakes with wb1_ready=1.
- State PIPE_PRI:
  - If wb0_valid and wb0_rd!=0, WB0 drives the port and wb1_ready=0.
  - Otherwise, if wb1_valid, WB1 drives the port and wb1_ready=1.
  - pipe_stall=0.
- wait_cnt increments on each cycle where wb1_valid=1 and wb1_ready=0. It clears on any WB1 handshake, or when wb1_valid=0.
- Transition to FORCE: in PIPE_PRI, when wb1_valid and wb1_ready=0 and wait_cnt==MAX_WAIT-1, next state=FORCE.
- State FORCE (one cycle):
  - pipe_stall=1 and wb1_ready=1; WB1 drives the port; WB0 is ignored.
  - If wb1_valid has dropped, the port is idle, but the stall is still asserted.
  - Next state=PIPE_PRI and wait_cnt=0.
- pipe_stall is a registered-state decode and is never asserted in PIPE_PRI.
- Scoreboard and outstanding count:
  - issue_ready = (out_cnt<MAX_OUT) and (issue_rd==0 or busy[issue_rd]==0).
  - An accepted issue increments out_cnt and sets busy[issue_rd] (rd!=0) at the next edge.
  - A WB1 handshake decrements out_cnt and clears busy[wb1_rd].
  - Same-cycle issue and WB1 handshake: out_cnt unchanged. Same rd in both: the set wins, so the bit stays 1.
  - A WB1 handshake with out_cnt==0 leaves out_cnt at 0 (saturate). A WB1 with a non-busy rd is still written.
- A mid-operation reset drops any in-flight grant immediately. Write-port outputs are 0 while nrst=0.

Decomposition:
- Package rf_pkg: XLEN default, NREG=32, REG_AW=5, state enum arb_state_t {PIPE_PRI, FORCE}.
- Sub-module rf_scoreboard: owns the busy vector, out_cnt and issue_ready.
- Top level: owns the FSM, wait_cnt and the port mux.

Test Plan:
- Reset, then wb0_valid=1, wb0_rd=5, wb0_data=0xDEADBEEF -> same cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; wb1_ready=0, pipe_stall=0.
- wb0_valid=1 with rd=0, and wb1_valid=1 with rd=7, data=0x11 -> rf_we=1, rf_a3=7, wb1_ready=1; no write to x0.
- Starvation (MAX_WAIT=4): wb0 writes rd=3 and wb1_valid with rd=9 every cycle.
  - Cycles 0-3: wb1 refused, wb1_ready=0.
  - Cycle 4: pipe_stall=1, wb1_ready=1, rf_a3=9.
  - Cycle 5: back to WB0 priority.
- Scoreboard:
  - issue rd=10 -> busy[10]=1 next cycle.
  - A second issue rd=10 -> issue_ready=0.
  - WB1 handshake rd=10 -> busy[10]=0 and issue_ready=1 the next cycle.
- Fill out_cnt to MAX_OUT=4 with rd=1..4 -> issue_ready=0 for rd=5.
  - Simultaneous issue rd=5 and WB1 handshake rd=1 -> the issue is not accepted this cycle.
  - The following cycle issue rd=5 is accepted; busy[5]=1, busy[1]=0.
- Assert nrst=0 asynchronously during FORCE with busy=0x0000_0400 -> outputs and busy go to 0 immediately. After release the state is PIPE_PRI.
